// File: rtl/alu_pkg.sv
// alu_pkg: shared op-code encoding and the result flag bundle for the
// pipelined ALU and any model that reuses alu_core.
package alu_pkg;

    localparam logic [2:0] OP_NOT = 3'b000;
    localparam logic [2:0] OP_AND = 3'b001;
    localparam logic [2:0] OP_OR  = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_ADD = 3'b100;
    localparam logic [2:0] OP_SUB = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_SHR = 3'b111;

    typedef struct packed {
        logic of;
        logic cary;
        logic eq;
    } alu_flags_t;

endpackage

// File: rtl/alu_if.sv
// alu_if: operation-in / result-out valid-ready bus of the pipelined ALU.
// master = operand source and result sink, slave = the ALU.
interface alu_if #(
    parameter int WIDTH = 32
);
    import alu_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             of;
    logic             cary;
    logic             eq;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, s, of, cary, eq
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, s, of, cary, eq
    );

endinterface

// File: rtl/alu_core.sv
// alu_core: combinational WIDTH-bit ALU producing the result and the
// overflow / carry / equal flags for one operation.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] s,
    output alu_flags_t       flags
);

    localparam int             SHW = $clog2(WIDTH);
    localparam logic [WIDTH:0] ONE = {{WIDTH{1'b0}}, 1'b1};

    logic [SHW-1:0]          sh_amt;
    logic [WIDTH:0]          sum_x;
    logic [WIDTH:0]          diff_x;
    logic [WIDTH:0]          shl_x;
    logic signed [WIDTH-1:0] a_sgn;
    logic signed [WIDTH-1:0] b_sgn;
    logic signed [WIDTH-1:0] sum_sgn;
    logic signed [WIDTH-1:0] diff_sgn;
    logic                    add_of;
    logic                    sub_of;

    // Only the low log2(WIDTH) bits of b form the shift count, so it never reaches WIDTH.
    assign sh_amt = b[SHW-1:0];

    // Extra top bit captures carry-out; subtraction is a + ~b + 1 so its carry means a >= b.
    assign sum_x  = {1'b0, a} + {1'b0, b};
    assign diff_x = {1'b0, a} + {1'b0, ~b} + ONE;
    // Bit WIDTH of the widened left shift is the last bit pushed out of a (0 for shift 0).
    assign shl_x  = {1'b0, a} << sh_amt;

    assign a_sgn    = $signed(a);
    assign b_sgn    = $signed(b);
    assign sum_sgn  = $signed(sum_x[WIDTH-1:0]);
    assign diff_sgn = $signed(diff_x[WIDTH-1:0]);

    // Signed overflow: same-sign operands for add (opposite for sub) giving a result of the other sign.
    assign add_of = ((a_sgn < 0) == (b_sgn < 0)) && ((sum_sgn < 0) != (a_sgn < 0));
    assign sub_of = ((a_sgn < 0) != (b_sgn < 0)) && ((diff_sgn < 0) != (a_sgn < 0));

    // Select result and flags by op code; eq is independent of the operation.
    always_comb begin
        s          = '0;
        flags.of   = 1'b0;
        flags.cary = 1'b0;
        flags.eq   = (a == b);
        case (op)
            OP_NOT: s = ~a;
            OP_AND: s = a & b;
            OP_OR:  s = a | b;
            OP_XOR: s = a ^ b;
            OP_ADD: begin
                s          = sum_x[WIDTH-1:0];
                flags.cary = sum_x[WIDTH];
                flags.of   = add_of;
            end
            OP_SUB: begin
                s          = diff_x[WIDTH-1:0];
                flags.cary = diff_x[WIDTH];
                flags.of   = sub_of;
            end
            OP_SHL: begin
                s          = shl_x[WIDTH-1:0];
                flags.cary = shl_x[WIDTH];
            end
            OP_SHR: s = a >> sh_amt;
            default: s = '0;
        endcase
    end

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined ALU with valid/ready on both sides.
// Stage 1 holds the operation, stage 2 holds the computed result and flags.
// Optional feature macro: ALU_STICKY_OF_EN adds a latched overflow flag
// (sticky_of) cleared by clr_sticky; without it sticky_of is constant 0.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic  clk,
    input  logic  rst_n,
    alu_if.slave  bus,
    input  logic  clr_sticky,
    output logic  sticky_of
);

    logic             vld_p1;
    logic [2:0]       op_p1;
    logic [WIDTH-1:0] a_p1;
    logic [WIDTH-1:0] b_p1;

    logic             vld_p2;
    logic [WIDTH-1:0] s_p2;
    alu_flags_t       flags_p2;

    logic [WIDTH-1:0] core_s;
    alu_flags_t       core_flags;
    logic             adv_p2;

    // A stage may load when it is empty or its occupant leaves this cycle.
    assign adv_p2       = !vld_p2 || bus.out_ready;
    assign bus.in_ready = !vld_p1 || adv_p2;

    // ---- input -> stage 1 ----
    // Stage 1 valid bit tracks whether an accepted operation is waiting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
        end else if (bus.in_ready) begin
            vld_p1 <= bus.in_valid;
        end
    end

    // Stage 1 operands captured only on an input transfer; contents are meaningless while invalid.
    always_ff @(posedge clk) begin
        if (bus.in_valid && bus.in_ready) begin
            op_p1 <= bus.op;
            a_p1  <= bus.a;
            b_p1  <= bus.b;
        end
    end

    alu_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .op    (op_p1),
        .a     (a_p1),
        .b     (b_p1),
        .s     (core_s),
        .flags (core_flags)
    );

    // ---- stage 1 -> stage 2 ----
    // Stage 2 advances when free; result held stable under backpressure and kept when emptying.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p2   <= 1'b0;
            s_p2     <= '0;
            flags_p2 <= '0;
        end else if (adv_p2) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                s_p2     <= core_s;
                flags_p2 <= core_flags;
            end
        end
    end

    assign bus.out_valid = vld_p2;
    assign bus.s         = s_p2;
    assign bus.of        = flags_p2.of;
    assign bus.cary      = flags_p2.cary;
    assign bus.eq        = flags_p2.eq;

`ifdef ALU_STICKY_OF_EN
    logic sticky_r;

    // Latch overflow on any delivered result; a new event beats a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_r <= 1'b0;
        end else if (vld_p2 && bus.out_ready && flags_p2.of) begin
            sticky_r <= 1'b1;
        end else if (clr_sticky) begin
            sticky_r <= 1'b0;
        end
    end

    assign sticky_of = sticky_r;
`else
    logic unused_clr_sticky;

    assign unused_clr_sticky = clr_sticky;
    assign sticky_of         = 1'b0;
`endif

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed and randomized stimulus for alu_pipe (WIDTH=32),
// checked against a plain-arithmetic reference model and an in-order queue.
module tb_alu_pipe;
    import alu_pkg::*;

    localparam int W = 32;
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;
`ifdef ALU_STICKY_OF_EN
    localparam bit STICKY_EN = 1'b1;
`else
    localparam bit STICKY_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clr_sticky = 1'b0;
    logic sticky_of;

    always #5 clk = ~clk;

    alu_if #(.WIDTH(W)) bus ();

    alu_pipe #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .clr_sticky (clr_sticky),
        .sticky_of  (sticky_of)
    );

    typedef struct {
        logic [31:0] s;
        logic        of;
        logic        cy;
        logic        eq;
        int          acc;
    } exp_t;

    exp_t        q[$];
    exp_t        fixed_e;
    int          total = 0;
    int          passes = 0;
    int          fails = 0;
    int          cyc = 0;
    int          delivered = 0;
    logic        stall_prev = 1'b0;
    logic [31:0] held_s = '0;
    logic [2:0]  held_f = '0;
    logic        st_model = 1'b0;
    logic        last_acc = 1'b0;
    logic        chk_lat = 1'b0;
    logic        use_fixed = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        assert (got === want) passes++;
        else begin
            fails++;
            $error("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    // Behavioural model: results straight from integer arithmetic.
    function automatic void ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] s, output logic of, output logic cy,
                                    output logic eq);
        longint          sa, sb, r;
        longint unsigned ua, ub;
        int              sh;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        sh = int'(b[4:0]);
        s  = '0;
        of = 1'b0;
        cy = 1'b0;
        eq = (a == b);
        case (op)
            OP_NOT: s = ~a;
            OP_AND: s = a & b;
            OP_OR:  s = a | b;
            OP_XOR: s = a ^ b;
            OP_ADD: begin
                s  = a + b;
                cy = (ua + ub) > 64'h0000_0000_FFFF_FFFF;
                r  = sa + sb;
                of = (r > SMAX) || (r < SMIN);
            end
            OP_SUB: begin
                s  = a - b;
                cy = (a >= b);
                r  = sa - sb;
                of = (r > SMAX) || (r < SMIN);
            end
            OP_SHL: begin
                s  = a << sh;
                cy = (sh == 0) ? 1'b0 : a[32-sh];
            end
            default: s = a >> sh;
        endcase
    endfunction

    // One clock cycle: drive at negedge, check, predict, cross posedge, return at negedge.
    task automatic step(input logic iv, input logic [2:0] iop, input logic [31:0] ia,
                        input logic [31:0] ib, input logic ordy, input logic clr);
        exp_t e, d;
        logic dlv;
        bus.in_valid = iv;
        bus.op       = iop;
        bus.a        = ia;
        bus.b        = ib;
        bus.out_ready = ordy;
        clr_sticky   = clr;
        #1;
        chk("in_ready", {31'd0, bus.in_ready}, (q.size() == 2) ? {31'd0, ordy} : 32'd1);
        if (stall_prev) begin
            chk("stall s", bus.s, held_s);
            chk("stall flags", {29'd0, bus.of, bus.cary, bus.eq}, {29'd0, held_f});
        end
        dlv = 1'b0;
        if (bus.out_valid) begin
            if (q.size() == 0) begin
                chk("out_valid with nothing in flight", {31'd0, bus.out_valid}, 32'd0);
            end else if (ordy) begin
                d   = q.pop_front();
                dlv = 1'b1;
                delivered++;
                chk("s", bus.s, d.s);
                chk("of", {31'd0, bus.of}, {31'd0, d.of});
                chk("cary", {31'd0, bus.cary}, {31'd0, d.cy});
                chk("eq", {31'd0, bus.eq}, {31'd0, d.eq});
                if (chk_lat) chk("latency", cyc - d.acc, 32'd2);
            end
        end
        stall_prev = bus.out_valid && !ordy;
        held_s     = bus.s;
        held_f     = {bus.of, bus.cary, bus.eq};
        last_acc   = iv && bus.in_ready;
        if (last_acc) begin
            if (use_fixed) e = fixed_e;
            else ref_alu(iop, ia, ib, e.s, e.of, e.cy, e.eq);
            e.acc = cyc;
            q.push_back(e);
        end
        if (STICKY_EN) begin
            if (dlv && d.of) st_model = 1'b1;
            else if (clr) st_model = 1'b0;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
        chk("sticky_of", {31'd0, sticky_of}, {31'd0, st_model});
    endtask

    task automatic send_fixed(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] es, input logic eof, input logic ecy,
                              input logic eeq);
        fixed_e.s  = es;
        fixed_e.of = eof;
        fixed_e.cy = ecy;
        fixed_e.eq = eeq;
        fixed_e.acc = 0;
        use_fixed = 1'b1;
        step(1'b1, op, a, b, 1'b1, 1'b0);
        use_fixed = 1'b0;
        chk("fixed accepted", {31'd0, last_acc}, 32'd1);
    endtask

    task automatic drain(input logic rand_rdy);
        int guard;
        guard = 0;
        while (q.size() != 0 && guard < 200) begin
            step(1'b0, OP_NOT, '0, '0, rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1, 1'b0);
            guard++;
        end
        chk("drain left in flight", q.size(), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time %0t reached limit %0t", $time, 200000);
        $fatal(1, "watchdog");
    end

    initial begin
        int          sent, guard, base;
        logic [31:0] ra, rb;
        logic [2:0]  rop;

        bus.in_valid  = 1'b0;
        bus.op        = OP_NOT;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b0;
        clr_sticky    = 1'b0;
        rst_n         = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("reset s", bus.s, 32'd0);
        chk("reset flags", {29'd0, bus.of, bus.cary, bus.eq}, 32'd0);
        chk("reset sticky", {31'd0, sticky_of}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // NOT stream, back-to-back, fixed latency
        chk_lat = 1'b1;
        send_fixed(OP_NOT, 32'h00000000, 32'h12345678, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
        send_fixed(OP_NOT, 32'hFFFFFFFF, 32'h12345678, 32'h00000000, 1'b0, 1'b0, 1'b0);
        send_fixed(OP_NOT, 32'hFFFF0000, 32'h12345678, 32'h0000FFFF, 1'b0, 1'b0, 1'b0);
        send_fixed(OP_NOT, 32'h0000FFFF, 32'h12345678, 32'hFFFF0000, 1'b0, 1'b0, 1'b0);
        send_fixed(OP_NOT, 32'hAAAAAAAA, 32'h12345678, 32'h55555555, 1'b0, 1'b0, 1'b0);
        drain(1'b0);
        chk_lat = 1'b0;

        // arithmetic, logic and shift corner vectors
        send_fixed(OP_ADD, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b1, 1'b0, 1'b0);
        send_fixed(OP_ADD, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1'b1, 1'b0);
        send_fixed(OP_SUB, 32'h00000005, 32'h00000005, 32'h00000000, 1'b0, 1'b1, 1'b1);
        send_fixed(OP_SUB, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
        send_fixed(OP_SHL, 32'h80000001, 32'h00000001, 32'h00000002, 1'b0, 1'b1, 1'b0);
        send_fixed(OP_SHR, 32'h80000002, 32'h00000021, 32'h40000001, 1'b0, 1'b0, 1'b0);
        send_fixed(OP_SHL, 32'hDEADBEEF, 32'h00000000, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0);
        send_fixed(OP_SHR, 32'h12345678, 32'h00000000, 32'h12345678, 1'b0, 1'b0, 1'b0);
        send_fixed(OP_AND, 32'h5A5A5A5A, 32'h5A5A5A5A, 32'h5A5A5A5A, 1'b0, 1'b0, 1'b1);
        send_fixed(OP_OR,  32'hF0F00000, 32'h000F0F00, 32'hF0FF0F00, 1'b0, 1'b0, 1'b0);
        send_fixed(OP_XOR, 32'hFF00FF00, 32'h0FF00FF0, 32'hF0F0F0F0, 1'b0, 1'b0, 1'b0);
        drain(1'b0);

        // 10 ADDs under random backpressure
        base  = delivered;
        sent  = 0;
        guard = 0;
        ra    = $urandom;
        rb    = $urandom;
        while (sent < 10 && guard < 300) begin
            step(1'b1, OP_ADD, ra, rb, 1'($urandom_range(0, 1)), 1'b0);
            if (last_acc) begin
                sent++;
                ra = $urandom;
                rb = $urandom;
            end
            guard++;
        end
        chk("backpressure ops sent", sent, 32'd10);
        drain(1'b1);
        chk("backpressure ops delivered", delivered - base, 32'd10);

        // random mixed ops under random backpressure
        base  = delivered;
        sent  = 0;
        guard = 0;
        while (sent < 60 && guard < 600) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = ra;
                1:       rb = 32'($urandom_range(0, 40));
                default: rb = $urandom;
            endcase
            step(1'b1, rop, ra, rb, 1'($urandom_range(0, 1)), 1'b0);
            if (last_acc) sent++;
            guard++;
        end
        drain(1'b1);
        chk("random ops delivered", delivered - base, sent);

        // sticky overflow: set wins over simultaneous clear, later clear alone drops it
        step(1'b0, OP_NOT, '0, '0, 1'b1, 1'b1);
        step(1'b1, OP_ADD, 32'h7FFFFFFF, 32'h00000001, 1'b1, 1'b0);
        step(1'b0, OP_NOT, '0, '0, 1'b0, 1'b0);
        step(1'b0, OP_NOT, '0, '0, 1'b1, 1'b1);
        chk("sticky after set+clear", {31'd0, sticky_of}, {31'd0, STICKY_EN});
        step(1'b0, OP_NOT, '0, '0, 1'b1, 1'b0);
        chk("sticky held", {31'd0, sticky_of}, {31'd0, STICKY_EN});
        step(1'b0, OP_NOT, '0, '0, 1'b1, 1'b1);
        chk("sticky cleared", {31'd0, sticky_of}, 32'd0);

        // asynchronous reset with two operations in flight
        step(1'b1, OP_ADD, 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0, 1'b0);
        step(1'b1, OP_XOR, 32'h0F0F0F0F, 32'h00FF00FF, 1'b0, 1'b0);
        chk("pre-reset out_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("pre-reset in_ready", {31'd0, bus.in_ready}, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("async reset out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("async reset s", bus.s, 32'd0);
        chk("async reset flags", {29'd0, bus.of, bus.cary, bus.eq}, 32'd0);
        chk("async reset sticky", {31'd0, sticky_of}, 32'd0);
        q.delete();
        stall_prev   = 1'b0;
        st_model     = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) step(1'b0, OP_NOT, '0, '0, 1'b1, 1'b0);
        chk("post-reset s", bus.s, 32'd0);
        chk("post-reset out_valid", {31'd0, bus.out_valid}, 32'd0);

        // pipeline resumes after reset
        send_fixed(OP_SUB, 32'h00000010, 32'h00000003, 32'h0000000D, 1'b0, 1'b1, 1'b0);
        drain(1'b0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
